adc_serial_capture: RTL and testbench

//  Front-end for the AD experiment. Periodically drives a TLC1549-style 10-bit serial ADC
//  (CS_n / I/O clock / DATA OUT) and shifts in each result. Holds the latest code on Data[9:0].

---
 rtl/adc_pkg.sv | 26 ++
 rtl/sample_tick_gen.sv | 34 +++
 rtl/adc_serial_capture.sv | 141 ++++++++++++++
 tb/tb_adc_serial_capture.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
// rtl/adc_pkg.sv - shared constants for the AD experiment capture and display stages
//
// Purpose: FSM state encodings for adc_serial_capture, ADC frame width and the
//          default timing constants (50 MHz system clock) shared with the
//          7-segment display stage.
// Ports:   none (package).
package adc_pkg;

  localparam int ADC_NBITS = 10;

  // Default timing at 50 MHz: 1 MHz SCLK, 22 us conversion, 1 kHz sample rate.
  localparam int DEF_CLK_DIV       = 25;
  localparam int DEF_CS_SETUP      = 10;
  localparam int DEF_CONV_WAIT     = 1100;
  localparam int DEF_SAMPLE_PERIOD = 50000;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_SETUP     = 2'd1;
  localparam logic [1:0] ST_SHIFT     = 2'd2;
  localparam logic [1:0] ST_CONV_WAIT = 2'd3;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// rtl/sample_tick_gen.sv - free-running period counter producing a one-cycle sample tick
//
// Purpose: counts 0..PERIOD-1 and wraps; tick is high during the wrap cycle.
// Ports:
//   CLK    in  1  system clock
//   RST_n  in  1  asynchronous active-low reset (counter to 0)
//   tick   out 1  high for one CLK cycle every PERIOD cycles
module sample_tick_gen
  import adc_pkg::*;
#(
  parameter int PERIOD = DEF_SAMPLE_PERIOD
) (
  input  logic CLK,
  input  logic RST_n,
  output logic tick
);

  localparam int W = $clog2(PERIOD + 1);

  logic [W-1:0] cnt;

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      cnt <= '0;
    end else if (cnt == W'(PERIOD - 1)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

  assign tick = (cnt == W'(PERIOD - 1));

endmodule

// File: rtl/adc_serial_capture.sv
// rtl/adc_serial_capture.sv - periodic TLC1549-style serial ADC capture front-end
//
// Purpose: on every accepted sample tick runs one CS_n/SCLK frame, shifts in
//          NBITS bits MSB first and publishes the result on Data with a
//          one-cycle DataValid. The ADC is pipelined, so each frame returns the
//          previous conversion; the first frame after reset is discarded.
// Ports:
//   CLK        in  1      system clock
//   RST_n      in  1      asynchronous active-low reset
//   ADC_DOUT   in  1      serial data from ADC (asynchronous to CLK)
//   ADC_CS_n   out 1      ADC chip select, active low
//   ADC_SCLK   out 1      ADC I/O clock, idles low
//   Data       out NBITS  last captured code, held between updates
//   DataValid  out 1      one-cycle pulse when Data updates
//   Busy       out 1      high whenever the FSM is not idle
module adc_serial_capture
  import adc_pkg::*;
#(
  parameter int NBITS         = ADC_NBITS,
  parameter int CLK_DIV       = DEF_CLK_DIV,
  parameter int CS_SETUP      = DEF_CS_SETUP,
  parameter int CONV_WAIT     = DEF_CONV_WAIT,
  parameter int SAMPLE_PERIOD = DEF_SAMPLE_PERIOD
) (
  input  logic             CLK,
  input  logic             RST_n,
  input  logic             ADC_DOUT,
  output logic             ADC_CS_n,
  output logic             ADC_SCLK,
  output logic [NBITS-1:0] Data,
  output logic             DataValid,
  output logic             Busy
);

  // One timer serves both SETUP and CONV_WAIT since they never overlap.
  localparam int TW = $clog2(max_int(CS_SETUP, CONV_WAIT) + 1);
  localparam int PW = $clog2(CLK_DIV + 1);
  localparam int BW = $clog2(NBITS + 1);

  logic [1:0]       state;
  logic [TW-1:0]    timer;
  logic [PW-1:0]    phase;
  logic [BW-1:0]    bits_done;   // SCLK rising edges issued in this frame
  logic [NBITS-1:0] shreg;
  logic             primed;
  logic             dout_meta;
  logic             dout_sync;
  logic             tick;

  sample_tick_gen #(
    .PERIOD (SAMPLE_PERIOD)
  ) u_tick (
    .CLK   (CLK),
    .RST_n (RST_n),
    .tick  (tick)
  );

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      dout_meta <= 1'b0;
      dout_sync <= 1'b0;
    end else begin
      dout_meta <= ADC_DOUT;
      dout_sync <= dout_meta;
    end
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state     <= ST_IDLE;
      ADC_CS_n  <= 1'b1;
      ADC_SCLK  <= 1'b0;
      timer     <= '0;
      phase     <= '0;
      bits_done <= '0;
      shreg     <= '0;
      primed    <= 1'b0;
      Data      <= '0;
      DataValid <= 1'b0;
    end else begin
      DataValid <= 1'b0;
      case (state)
        ST_IDLE: begin
          // Ticks arriving in any other state are simply ignored.
          if (tick) begin
            state    <= ST_SETUP;
            ADC_CS_n <= 1'b0;
            timer    <= '0;
          end
        end
        ST_SETUP: begin
          if (timer == TW'(CS_SETUP - 1)) begin
            // First rising edge; the bit is captured on the edge that raises SCLK.
            state     <= ST_SHIFT;
            ADC_SCLK  <= 1'b1;
            shreg     <= {shreg[NBITS-2:0], dout_sync};
            bits_done <= BW'(1);
            phase     <= '0;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        ST_SHIFT: begin
          if (phase == PW'(CLK_DIV - 1)) begin
            phase <= '0;
            if (ADC_SCLK) begin
              ADC_SCLK <= 1'b0;
            end else if (bits_done == BW'(NBITS)) begin
              // Last low half-period done: end the frame and publish.
              state    <= ST_CONV_WAIT;
              ADC_CS_n <= 1'b1;
              timer    <= '0;
              primed   <= 1'b1;
              if (primed) begin
                Data      <= shreg;
                DataValid <= 1'b1;
              end
            end else begin
              ADC_SCLK  <= 1'b1;
              shreg     <= {shreg[NBITS-2:0], dout_sync};
              bits_done <= bits_done + BW'(1);
            end
          end else begin
            phase <= phase + PW'(1);
          end
        end
        ST_CONV_WAIT: begin
          if (timer == TW'(CONV_WAIT - 1)) begin
            state <= ST_IDLE;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign Busy = (state != ST_IDLE);

endmodule

// File: tb/tb_adc_serial_capture.sv
// tb/tb_adc_serial_capture.sv - self-checking bench for adc_serial_capture with a pipelined ADC model
module tb_adc_serial_capture;

  localparam int NB        = 10;
  localparam int CD        = 4;
  localparam int CSS       = 3;
  localparam int CW        = 20;
  localparam int SP        = 200;
  localparam int SP_F      = 50;
  localparam int FRAME_LEN = 1 + CSS + 2 * CD * NB + CW;
  localparam int BUSY_LEN  = FRAME_LEN - 1;
  // A frame starts on the first tick at or after the previous frame ends.
  localparam int STEP      = ((FRAME_LEN + SP - 1) / SP) * SP;
  localparam int STEP_F    = ((FRAME_LEN + SP_F - 1) / SP_F) * SP_F;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n = 1'b0;
  logic          rst_f = 1'b0;
  logic          adc_dout = 1'b0;
  logic          cs_n, sclk, dv, busy;
  logic [NB-1:0] data;
  logic          cs_n_f, sclk_f, dv_f, busy_f;
  logic [NB-1:0] data_f;
  logic          dout_f = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;

  adc_serial_capture #(
    .NBITS(NB), .CLK_DIV(CD), .CS_SETUP(CSS), .CONV_WAIT(CW), .SAMPLE_PERIOD(SP)
  ) dut (
    .CLK(clk), .RST_n(rst_n), .ADC_DOUT(adc_dout), .ADC_CS_n(cs_n), .ADC_SCLK(sclk),
    .Data(data), .DataValid(dv), .Busy(busy)
  );

  adc_serial_capture #(
    .NBITS(NB), .CLK_DIV(CD), .CS_SETUP(CSS), .CONV_WAIT(CW), .SAMPLE_PERIOD(SP_F)
  ) dut_fast (
    .CLK(clk), .RST_n(rst_f), .ADC_DOUT(dout_f), .ADC_CS_n(cs_n_f), .ADC_SCLK(sclk_f),
    .Data(data_f), .DataValid(dv_f), .Busy(busy_f)
  );

  // Pipelined ADC: each frame shifts out the code converted at the end of the previous one.
  logic [NB-1:0] adc_next_code = 10'h2A5;
  logic [NB-1:0] adc_prev      = 10'h1C3;
  logic [NB-1:0] adc_sh        = '0;

  always @(negedge cs_n) begin
    adc_sh   = adc_prev;
    adc_dout = adc_sh[NB-1];
  end
  always @(negedge sclk) begin
    if (!cs_n) begin
      adc_sh   = {adc_sh[NB-2:0], 1'b0};
      adc_dout = adc_sh[NB-1];
    end
  end
  always @(posedge cs_n) adc_prev = adc_next_code;

  // Monitor of the main instance: per-frame records, sampled on the falling CLK edge.
  typedef struct {
    int            fall_cyc;
    int            rises;
    int            first_delay;
    int            bad_runs;
    logic          dv;
    logic [NB-1:0] data;
  } frame_t;

  frame_t frame_q[$];
  int cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  logic          p_cs = 1'b1, p_sclk = 1'b0, p_busy = 1'b0, p_dv = 1'b0;
  logic [NB-1:0] p_data = '0;
  int m_fall, m_rises = 0, m_first, m_bad, run_len;
  int busy_run = 0, last_busy_len = -1;
  int sclk_idle_bad = 0, dv_total = 0, dv_wide = 0, dv_misplaced = 0, data_glitch = 0;

  always @(negedge clk) begin
    frame_t rec;
    logic   cs_rise;
    cs_rise = !p_cs && cs_n;
    if (cs_n === 1'b1 && sclk !== 1'b0) sclk_idle_bad++;
    if (p_cs && !cs_n) begin
      m_fall = cyc; m_rises = 0; m_first = -1; m_bad = 0; run_len = 1;
    end else if (!cs_n) begin
      if (sclk != p_sclk) begin
        if (sclk && m_rises == 0) m_first = run_len;
        else if (run_len != CD)   m_bad++;
        if (sclk) m_rises++;
        run_len = 1;
      end else begin
        run_len++;
      end
    end else if (cs_rise) begin
      if (run_len != CD || p_sclk) m_bad++;
      rec = '{m_fall, m_rises, m_first, m_bad, dv, data};
      frame_q.push_back(rec);
    end
    if (dv) begin
      dv_total++;
      if (p_dv) dv_wide++;
      if (!cs_rise) dv_misplaced++;
    end
    if (rst_n && data != p_data && !dv) data_glitch++;
    if (busy) busy_run++;
    else if (p_busy) begin last_busy_len = busy_run; busy_run = 0; end
    p_cs = cs_n; p_sclk = sclk; p_busy = busy; p_dv = dv; p_data = data;
  end

  // Monitor of the fast-tick instance.
  int cyc_f;
  always @(posedge clk or negedge rst_f) begin
    if (!rst_f) cyc_f <= 0;
    else        cyc_f <= cyc_f + 1;
  end

  int   f_falls[$];
  int   f_rises_cs = 0, f_dv = 0, f_hi_run = 0, f_min_gap = 1 << 30, f_data_bad = 0;
  logic pf_cs = 1'b1;

  always @(negedge clk) begin
    if (rst_f) begin
      if (pf_cs && !cs_n_f) begin
        f_falls.push_back(cyc_f);
        if (f_rises_cs > 0 && f_hi_run < f_min_gap) f_min_gap = f_hi_run;
      end
      if (!pf_cs && cs_n_f) begin f_rises_cs++; f_hi_run = 0; end
      if (cs_n_f) f_hi_run++;
      if (dv_f) begin
        f_dv++;
        if (data_f !== 10'h3FF) f_data_bad++;
      end
      pf_cs = cs_n_f;
    end
  end

  // Reference model state: expectations derived from frame count and codes fed.
  int            frames_since_reset = 0;
  int            exp_fall = 0;
  int            exp_dv_count = 0;
  logic          exp_dv = 1'b0;
  logic [NB-1:0] exp_data = '0;
  logic [NB-1:0] last_conv = '0;

  task automatic wait_frame(output frame_t r, output bit ok);
    int t = 0;
    while (frame_q.size() == 0 && t < 3 * SP) begin
      @(negedge clk); #1;
      t++;
    end
    if (frame_q.size() == 0) begin
      ok = 1'b0;
      n_checks++; n_fail++;
      $display("FAIL frame_timeout: no frame within %0d cycles", 3 * SP);
      r = '{default: 0};
    end else begin
      ok = 1'b1;
      r = frame_q.pop_front();
    end
  endtask

  task automatic next_frame(output frame_t r);
    bit ok;
    wait_frame(r, ok);
    frames_since_reset++;
    exp_dv   = (frames_since_reset >= 2);
    exp_data = last_conv;
    exp_fall = SP + (frames_since_reset - 1) * STEP;
    if (exp_dv) exp_dv_count++;
    last_conv = adc_next_code;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rst_f = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk); #1;
    n_checks++; if (cs_n !== 1'b1)  begin n_fail++; $display("FAIL reset_cs_n: got %b want 1", cs_n); end
    n_checks++; if (sclk !== 1'b0)  begin n_fail++; $display("FAIL reset_sclk: got %b want 0", sclk); end
    n_checks++; if (data !== '0)    begin n_fail++; $display("FAIL reset_data: got %h want 000", data); end
    n_checks++; if (dv !== 1'b0)    begin n_fail++; $display("FAIL reset_dv: got %b want 0", dv); end
    n_checks++; if (busy !== 1'b0)  begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    #1; rst_n = 1'b1; rst_f = 1'b1;
    repeat (150) @(negedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0 || cs_n !== 1'b1) begin
      n_fail++; $display("FAIL idle_before_tick: busy=%b cs_n=%b want 0/1", busy, cs_n);
    end
  endtask

  task automatic test_first_frames();
    frame_t r;
    next_frame(r);
    n_checks++; if (r.fall_cyc != exp_fall) begin n_fail++; $display("FAIL first_tick_cycle: got %0d want %0d", r.fall_cyc, exp_fall); end
    n_checks++; if (r.dv !== 1'b0) begin n_fail++; $display("FAIL frame1_no_dv: got %b want 0", r.dv); end
    n_checks++; if (r.data !== '0) begin n_fail++; $display("FAIL frame1_data_held: got %h want 000", r.data); end
    next_frame(r);
    n_checks++; if (r.dv !== exp_dv) begin n_fail++; $display("FAIL frame2_dv: got %b want %b", r.dv, exp_dv); end
    n_checks++; if (r.data !== exp_data) begin n_fail++; $display("FAIL frame2_data: got %h want %h", r.data, exp_data); end
  endtask

  task automatic test_codes();
    frame_t        r;
    logic [NB-1:0] codes[6];
    codes[0] = 10'h000; codes[1] = 10'h3FF; codes[2] = 10'h200;
    codes[3] = NB'($urandom_range(1, 1023)); codes[4] = NB'($urandom_range(1, 1023));
    codes[5] = NB'($urandom_range(1, 1023));
    for (int i = 0; i < 8; i++) begin
      if (i < 6) adc_next_code = codes[i];
      next_frame(r);
      n_checks++;
      if (r.dv !== exp_dv || r.data !== exp_data) begin
        n_fail++;
        $display("FAIL code_frame%0d: dv=%b data=%h want dv=%b data=%h", i, r.dv, r.data, exp_dv, exp_data);
      end
    end
    n_checks++; if (data_glitch != 0) begin n_fail++; $display("FAIL data_stable: %0d changes without DataValid, want 0", data_glitch); end
    n_checks++; if (dv_total != exp_dv_count) begin n_fail++; $display("FAIL dv_count: got %0d want %0d", dv_total, exp_dv_count); end
  endtask

  task automatic test_timing();
    frame_t r;
    for (int i = 0; i < 2; i++) begin
      adc_next_code = NB'($urandom);
      next_frame(r);
      n_checks++; if (r.fall_cyc != exp_fall) begin n_fail++; $display("FAIL tick_to_cs: fall at %0d want %0d", r.fall_cyc, exp_fall); end
      n_checks++; if (r.first_delay != CSS) begin n_fail++; $display("FAIL cs_setup: got %0d want %0d", r.first_delay, CSS); end
      n_checks++; if (r.rises != NB) begin n_fail++; $display("FAIL sclk_rises: got %0d want %0d", r.rises, NB); end
      n_checks++; if (r.bad_runs != 0) begin n_fail++; $display("FAIL sclk_half_period: %0d runs not %0d cycles", r.bad_runs, CD); end
      n_checks++; if (r.dv !== exp_dv || r.data !== exp_data) begin n_fail++; $display("FAIL timing_data: got %h want %h", r.data, exp_data); end
    end
    repeat (CW + 5) @(negedge clk);
    #1;
    n_checks++; if (last_busy_len != BUSY_LEN) begin n_fail++; $display("FAIL busy_length: got %0d want %0d", last_busy_len, BUSY_LEN); end
    n_checks++; if (sclk_idle_bad != 0) begin n_fail++; $display("FAIL sclk_idle: %0d cycles SCLK high with CS_n high, want 0", sclk_idle_bad); end
    n_checks++; if (dv_wide != 0 || dv_misplaced != 0) begin n_fail++; $display("FAIL dv_pulse: wide=%0d misplaced=%0d want 0/0", dv_wide, dv_misplaced); end
  endtask

  task automatic test_reset_midframe();
    frame_t r;
    int     t = 0;
    while (!(cs_n === 1'b0 && m_rises == 4) && t < 3 * SP) begin
      @(negedge clk); #1;
      t++;
    end
    n_checks++;
    if (!(cs_n === 1'b0 && m_rises == 4)) begin n_fail++; $display("FAIL midframe_wait: 4th rise not seen in %0d cycles", 3 * SP); end
    #1; rst_n = 1'b0; #1;
    n_checks++;
    if (cs_n !== 1'b1 || data !== '0 || sclk !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL async_abort: cs_n=%b data=%h sclk=%b busy=%b want 1/000/0/0", cs_n, data, sclk, busy);
    end
    repeat (3) @(posedge clk);
    @(negedge clk); #2;
    rst_n = 1'b1;
    frame_q.delete();
    frames_since_reset = 0;
    adc_next_code = NB'($urandom_range(1, 1023));
    next_frame(r);
    n_checks++; if (r.fall_cyc != exp_fall) begin n_fail++; $display("FAIL rearm_tick: fall at %0d want %0d", r.fall_cyc, exp_fall); end
    n_checks++; if (r.dv !== 1'b0 || r.data !== '0) begin n_fail++; $display("FAIL reprimed: dv=%b data=%h want 0/000", r.dv, r.data); end
    next_frame(r);
    n_checks++; if (r.dv !== exp_dv || r.data !== exp_data) begin n_fail++; $display("FAIL after_reset_data: dv=%b data=%h want %b/%h", r.dv, r.data, exp_dv, exp_data); end
  endtask

  task automatic test_slow_rate();
    int t = 0;
    while (f_falls.size() < 6 && t < 20 * STEP_F) begin
      @(negedge clk); #1;
      t++;
    end
    n_checks++;
    if (f_falls.size() < 6) begin
      n_fail++; $display("FAIL fast_frames: got %0d frames want 6", f_falls.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        n_checks++;
        if (f_falls[i] != SP_F + i * STEP_F) begin
          n_fail++; $display("FAIL fast_frame_start%0d: got %0d want %0d", i, f_falls[i], SP_F + i * STEP_F);
        end
      end
    end
    n_checks++; if (f_min_gap < CW) begin n_fail++; $display("FAIL fast_cs_gap: min %0d want >= %0d", f_min_gap, CW); end
    n_checks++; if (f_dv != f_rises_cs - 1) begin n_fail++; $display("FAIL fast_dv_count: got %0d want %0d", f_dv, f_rises_cs - 1); end
    n_checks++; if (f_data_bad != 0) begin n_fail++; $display("FAIL fast_data: %0d updates not 3FF", f_data_bad); end
  endtask

  initial begin
    test_reset();
    test_first_frames();
    test_codes();
    test_timing();
    test_reset_midframe();
    test_slow_rate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
